// File: rtl/atf_cfg_pkg.sv
// rtl/atf_cfg_pkg.sv - shared types and helpers for the ATF1502 fuse configuration path
package atf_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } cfg_state_t;

    localparam int JED_SUM_W = 16;
    localparam int GMUX_W    = 46;

    // JEDEC checksum: byte-wise sum that wraps modulo 2^16
    function automatic logic [JED_SUM_W-1:0] jed_byte_add(
        input logic [JED_SUM_W-1:0] sum,
        input logic [7:0]           byte_v
    );
        return sum + {{(JED_SUM_W-8){1'b0}}, byte_v};
    endfunction

endpackage

// File: rtl/jed_checksum.sv
// rtl/jed_checksum.sv - LSB-first byte accumulator and wrapping 16-bit JEDEC fuse sum
import atf_cfg_pkg::*;

module jed_checksum (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 bit_en,
    input  logic                 bit_in,
    input  logic [2:0]           bit_pos,
    input  logic                 flush,
    output logic [JED_SUM_W-1:0] sum
);

    logic [7:0]           acc_q, acc_d, byte_w;
    logic [JED_SUM_W-1:0] sum_q, sum_d;

    always_comb begin
        byte_w          = acc_q;
        byte_w[bit_pos] = bit_in;
        acc_d           = acc_q;
        sum_d           = sum_q;
        if (clear) begin
            acc_d = '0;
            sum_d = '0;
        end else if (bit_en) begin
            if (bit_pos == 3'd7) begin
                sum_d = jed_byte_add(sum_q, byte_w);
                acc_d = '0;
            end else begin
                acc_d = byte_w;
            end
        end else if (flush) begin
            sum_d = jed_byte_add(sum_q, acc_q);
            acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            sum_q <= '0;
        end else begin
            acc_q <= acc_d;
            sum_q <= sum_d;
        end
    end

    // During a flush the output already includes the zero-padded partial byte,
    // so the loader can compare in that same cycle.
    assign sum = flush ? jed_byte_add(sum_q, acc_q) : sum_q;

endmodule

// File: rtl/fuse_loader.sv
// rtl/fuse_loader.sv - serial JEDEC fuse loader with checksum qualification for the ATF1502 model
import atf_cfg_pkg::*;

module fuse_loader #(
    parameter int N_FUSES   = 16808,
    parameter int GMUX_BASE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [JED_SUM_W-1:0] expected_sum,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    output logic                 bit_ready,
    output logic [0:N_FUSES-1]   fuses,
    output logic [0:GMUX_W-1]    global_mux,
    output logic                 cfg_valid,
    output logic                 cfg_error,
    output logic                 busy
);

    localparam int               IDX_W    = $clog2(N_FUSES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FUSES - 1);
    localparam bit               PARTIAL  = (N_FUSES % 8) != 0;

    cfg_state_t           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [JED_SUM_W-1:0] exp_q, exp_d;
    logic [0:N_FUSES-1]   fuses_q;
    logic [JED_SUM_W-1:0] sum;
    logic                 accept, clear, flush;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        exp_d     = exp_q;
        clear     = 1'b0;
        bit_ready = 1'b0;
        busy      = 1'b0;
        cfg_valid = 1'b0;
        cfg_error = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                cfg_valid = (state_q == ST_DONE);
                cfg_error = (state_q == ST_ERROR);
                if (start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    exp_d   = expected_sum;
                    clear   = 1'b1;
                end
            end
            ST_LOAD: begin
                bit_ready = 1'b1;
                busy      = 1'b1;
                if (bit_valid) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                busy    = 1'b1;
                state_d = (sum == exp_q) ? ST_DONE : ST_ERROR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept = bit_ready && bit_valid;
    assign flush  = (state_q == ST_CHECK) && PARTIAL;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            exp_q   <= exp_d;
        end
    end

    // Array is deliberately not cleared on start; only reset wipes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fuses_q <= '0;
        end else if (accept) begin
            fuses_q[idx_q] <= bit_in;
        end
    end

    jed_checksum u_checksum (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .bit_en  (accept),
        .bit_in  (bit_in),
        .bit_pos (idx_q[2:0]),
        .flush   (flush),
        .sum     (sum)
    );

    assign fuses      = fuses_q;
    assign global_mux = fuses_q[GMUX_BASE +: GMUX_W];

endmodule
